regfile_nr: RTL and testbench

- Parametrised multi-port register file; the successor to the single 32-bit storage register.
- Holds DEPTH words of WIDTH bits, with one synchronous write port and NUM_RD independent read ports.
- Optional hardwired-zero entry 0, optional write-to-read bypass, and selectable read latency (0 or 1 cycle).
- Sits between the decode and execute stages of the core as the architectural integer register file.

---
 rtl/regfile_nr.sv | 92 +++++++++
 tb/tb_regfile_nr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_nr.sv
// Parametrised register file: DEPTH x WIDTH storage, one write port, NUM_RD read
// ports, optional hardwired-zero entry 0, optional write bypass, 0/1-cycle read latency.
module regfile_nr #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  generate
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("regfile_nr: DEPTH exceeds 2**ADDR_W");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_nr: NUM_RD must be 1..4");
    end
    if (READ_LAT != 0 && READ_LAT != 1) begin : g_bad_lat
      $error("regfile_nr: READ_LAT must be 0 or 1");
    end
  endgenerate

  // Range check uses every address bit, so aliases above DEPTH never hit storage.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  assign wr_ok = we && !res && in_range(wr_addr) &&
                 !((ZERO_R0 != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  val;

      assign addr = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
        val = '0;
        if (!in_range(addr)) begin
          val = '0;
        end else if ((ZERO_R0 != 0) && (addr == '0)) begin
          val = '0;
        end else if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
          val = wr_data;
        end else begin
          val = mem[addr[IDX_W-1:0]];
        end
      end

      if (READ_LAT == 1) begin : g_lat1
        logic [WIDTH-1:0] rd_q_p1;

        // Stage p1: registered read value, cleared by reset.
        always_ff @(posedge clk) begin
          if (res) rd_q_p1 <= '0;
          else     rd_q_p1 <= val;
        end

        assign rd_data[k*WIDTH +: WIDTH] = res ? '0 : rd_q_p1;
      end else begin : g_lat0
        assign rd_data[k*WIDTH +: WIDTH] = res ? '0 : val;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_nr.sv
// Directed bench for regfile_nr: six parameter variants share one stimulus stream,
// each checked against hand-computed read values.
module tb_regfile_nr;

  logic        clk = 1'b0;
  logic        res;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rda, rdb, rdc, rdd, rde, rdf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: defaults; b: no zero entry; c: no bypass; d/e: registered read; f: DEPTH=20
  regfile_nr #(.ZERO_R0(1), .BYPASS(1), .READ_LAT(0)) u_a (
    .clk(clk), .res(res), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rda));
  regfile_nr #(.ZERO_R0(0), .BYPASS(1), .READ_LAT(0)) u_b (
    .clk(clk), .res(res), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdb));
  regfile_nr #(.ZERO_R0(1), .BYPASS(0), .READ_LAT(0)) u_c (
    .clk(clk), .res(res), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdc));
  regfile_nr #(.ZERO_R0(1), .BYPASS(1), .READ_LAT(1)) u_d (
    .clk(clk), .res(res), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd));
  regfile_nr #(.ZERO_R0(1), .BYPASS(0), .READ_LAT(1)) u_e (
    .clk(clk), .res(res), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rde));
  regfile_nr #(.DEPTH(20), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1), .READ_LAT(0)) u_f (
    .clk(clk), .res(res), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    we = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    // Test 1: reset with a write pending, two edges
    res = 1'b1;
    wr(1'b1, 5'd3, 32'd100);
    rd(5'd3, 5'd31);
    tick();
    chk("rst_a_p0", rda[31:0], 32'd0);
    chk("rst_d_p0", rdd[31:0], 32'd0);
    tick();
    res = 1'b0;
    wr(1'b0, 5'd0, 32'd0);
    #1;
    chk("t1_a_p0", rda[31:0], 32'd0);
    chk("t1_a_p1", rda[63:32], 32'd0);
    chk("t1_f_p1", rdf[63:32], 32'd0);
    chk("t1_d_p0", rdd[31:0], 32'd0);
    tick();
    chk("t1_d_p0_next", rdd[31:0], 32'd0);

    // Test 2: basic write then read
    wr(1'b1, 5'd5, 32'd200);
    tick();
    wr(1'b1, 5'd6, 32'd300);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    rd(5'd5, 5'd6);
    #1;
    chk("t2_a_p0", rda[31:0], 32'd200);
    chk("t2_a_p1", rda[63:32], 32'd300);
    chk("t2_c_p1", rdc[63:32], 32'd300);
    chk("t2_f_p0", rdf[31:0], 32'd200);
    tick();
    chk("t2_d_p0", rdd[31:0], 32'd200);
    chk("t2_e_p1", rde[63:32], 32'd300);
    rd(5'd0, 5'd5);
    #1;
    chk("t2_a_r0", rda[31:0], 32'd0);
    chk("t2_b_r0", rdb[31:0], 32'd0);

    // Test 3: writes to entry 0
    tick();
    wr(1'b1, 5'd0, 32'hDEADBEEF);
    rd(5'd0, 5'd0);
    #1;
    chk("t3_a_byp_r0", rda[31:0], 32'd0);
    chk("t3_b_byp_r0", rdb[31:0], 32'hDEADBEEF);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    #1;
    chk("t3_a_r0", rda[31:0], 32'd0);
    chk("t3_c_r0", rdc[63:32], 32'd0);
    chk("t3_b_p0", rdb[31:0], 32'hDEADBEEF);
    chk("t3_b_p1", rdb[63:32], 32'hDEADBEEF);

    // Test 4: same-cycle write/read of address 7, combinational read
    tick();
    wr(1'b1, 5'd7, 32'd400);
    rd(5'd5, 5'd7);
    #1;
    chk("t4_a_byp", rda[63:32], 32'd400);
    chk("t4_c_old", rdc[63:32], 32'd0);
    chk("t4_a_p0", rda[31:0], 32'd200);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    #1;
    chk("t4_c_new", rdc[63:32], 32'd400);
    chk("t4_d_byp", rdd[63:32], 32'd400);
    chk("t4_e_old", rde[63:32], 32'd0);
    tick();
    chk("t4_e_new", rde[63:32], 32'd400);

    // Test 5: registered read with a write of 500 at the same edge
    wr(1'b1, 5'd7, 32'd500);
    #1;
    chk("t5_d_before", rdd[63:32], 32'd400);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    #1;
    chk("t5_d_byp", rdd[63:32], 32'd500);
    chk("t5_e_old", rde[63:32], 32'd400);
    chk("t5_d_p0", rdd[31:0], 32'd200);
    tick();
    chk("t5_e_new", rde[63:32], 32'd500);

    // Test 6: out-of-range write on DEPTH=20, then reset mid-operation
    wr(1'b1, 5'd25, 32'd77);
    rd(5'd25, 5'd25);
    #1;
    chk("t6_f_oor_byp", rdf[31:0], 32'd0);
    chk("t6_a_in_range", rda[31:0], 32'd77);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    #1;
    chk("t6_f_oor", rdf[63:32], 32'd0);
    chk("t6_a_25", rda[63:32], 32'd77);
    rd(5'd5, 5'd6);
    #1;
    chk("t6_f_5", rdf[31:0], 32'd200);
    chk("t6_f_6", rdf[63:32], 32'd300);
    wr(1'b1, 5'd4, 32'd88);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    rd(5'd4, 5'd4);
    #1;
    chk("t6_f_88", rdf[31:0], 32'd88);
    res = 1'b1;
    wr(1'b1, 5'd4, 32'd99);
    #1;
    chk("t6_f_in_res", rdf[31:0], 32'd0);
    chk("t6_a_in_res", rda[63:32], 32'd0);
    chk("t6_d_in_res", rdd[31:0], 32'd0);
    tick();
    res = 1'b0;
    wr(1'b0, 5'd0, 32'd0);
    rd(5'd4, 5'd5);
    #1;
    chk("t6_f_after", rdf[31:0], 32'd0);
    chk("t6_a_4_after", rda[31:0], 32'd0);
    chk("t6_a_5_after", rda[63:32], 32'd0);
    chk("t6_d_after", rdd[63:32], 32'd0);
    tick();
    chk("t6_d_4_reg", rdd[31:0], 32'd0);
    chk("t6_e_5_reg", rde[63:32], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
